// File: rtl/video_mode_sequencer_if.sv
// video_mode_sequencer_if: connects the mode sequencer to the video pipeline and the DRP engine.
//   mode_i        requested mode code (quasi-static, may glitch)
//   frame_start_i one-cycle pulse at the start of each output frame
//   mmcm_locked_i MMCM LOCKED (asynchronous)
//   ack_toggle_i  DRP engine toggles this once per completed request (asynchronous)
//   req_toggle_o  toggled once per reconfiguration request
//   state_sel_o   mode code handed to the DRP engine
//   pipe_rst_o    synchronous reset for capture/buffer/imageGen
//   blank_o       force black output, no TMDS data islands
//   busy_o        sequencer is not idle
//   timeout_err_o sticky abort flag
// master: the sequencer; slave: the pipeline/DRP side.
interface video_mode_sequencer_if #(parameter int MODE_W = 3);
    logic [MODE_W-1:0] mode_i;
    logic              frame_start_i;
    logic              mmcm_locked_i;
    logic              ack_toggle_i;
    logic              req_toggle_o;
    logic [MODE_W-1:0] state_sel_o;
    logic              pipe_rst_o;
    logic              blank_o;
    logic              busy_o;
    logic              timeout_err_o;
    modport master (
        input  mode_i, frame_start_i, mmcm_locked_i, ack_toggle_i,
        output req_toggle_o, state_sel_o, pipe_rst_o, blank_o, busy_o, timeout_err_o
    );
    modport slave (
        output mode_i, frame_start_i, mmcm_locked_i, ack_toggle_i,
        input  req_toggle_o, state_sel_o, pipe_rst_o, blank_o, busy_o, timeout_err_o
    );
endinterface

// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer: debounces a requested video mode, waits for a frame boundary, blanks and
// resets the pipeline, then hands the new state_sel to the DRP engine over a toggle handshake.
//   pxlClk  pixel clock
//   rst     synchronous, active-high reset
//   bus     video_mode_sequencer_if.master (mode request, frame pulse, lock/ack in; request and
//           pipeline control out)
module video_mode_sequencer #(
    parameter int MODE_W       = 3,
    parameter int DEFAULT_MODE = 0,
    parameter int RST_CYCLES   = 1000,
    parameter int DEBOUNCE     = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT      = 2**20
) (
    input logic                    pxlClk,
    input logic                    rst,
    video_mode_sequencer_if.master bus
);
    localparam int LOCK_CYCLES = 64;
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [MODE_W-1:0] DEF_MODE = MODE_W'(DEFAULT_MODE);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);
    typedef enum logic [2:0] {POR, IDLE, WAIT_FRAME, BLANK, WAIT_ACK, WAIT_LOCK, SETTLE} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, lock_sync_q;
    logic                   ack_prev_q, ack_prev_d;
    logic [MODE_W-1:0]      mode_prev_q, target_q, target_d, state_sel_q, state_sel_d;
    logic [DB_W-1:0]        stable_cnt_q, stable_cnt_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [LK_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                   req_q, req_d, err_q, err_d, blank_q, busy_q;
    logic                   ack_s, lock_s, mode_ok;
    assign ack_s  = ack_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    // A mode changing in this very cycle counts as unstable, so it beats a coincident frameStart.
    assign mode_ok = (stable_cnt_q == DB_MAX) && (bus.mode_i == mode_prev_q);
    assign stable_cnt_d = (bus.mode_i != mode_prev_q) ? '0 :
                          (stable_cnt_q == DB_MAX) ? stable_cnt_q : stable_cnt_q + DB_W'(1);
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        state_sel_d = state_sel_q;
        req_d       = req_q;
        ack_prev_d  = ack_prev_q;
        err_d       = err_q;
        rst_cnt_d   = rst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        lock_cnt_d  = '0;
        case (state_q)
            POR: begin
                // Any acknowledge seen here belongs to a request from before reset.
                ack_prev_d = ack_s;
                if (rst_cnt_q == RC_LAST) begin
                    state_d   = IDLE;
                    rst_cnt_d = '0;
                end else rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
            IDLE: if (mode_ok && bus.mode_i != state_sel_q) begin
                target_d = bus.mode_i;
                state_d  = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!mode_ok || bus.mode_i == state_sel_q) state_d = IDLE;
                else if (bus.frame_start_i) state_d = BLANK;
            end
            BLANK: begin
                state_sel_d = target_q;
                req_d       = ~req_q;
                tmo_cnt_d   = '0;
                state_d     = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s != ack_prev_q) begin
                    ack_prev_d = ack_s;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_LOCK;
                end else if (tmo_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    ack_prev_d = ack_s;
                    tmo_cnt_d  = tmo_cnt_q + TO_W'(1);
                    rst_cnt_d  = '0;
                    state_d    = SETTLE;
                end else tmo_cnt_d = tmo_cnt_q + TO_W'(1);
            end
            WAIT_LOCK: begin
                if (lock_s && lock_cnt_q == LK_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = SETTLE;
                end else if (tmo_cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    ack_prev_d = ack_s;
                    tmo_cnt_d  = tmo_cnt_q + TO_W'(1);
                    rst_cnt_d  = '0;
                    state_d    = SETTLE;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + TO_W'(1);
                    lock_cnt_d = lock_s ? lock_cnt_q + LK_W'(1) : '0;
                end
            end
            SETTLE: begin
                // Losing lock restarts the settle window.
                if (!lock_s) rst_cnt_d = '0;
                else if (rst_cnt_q == RC_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = IDLE;
                end else rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
            default: state_d = POR;
        endcase
    end
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state_q      <= POR;
            ack_sync_q   <= '0;
            lock_sync_q  <= '0;
            ack_prev_q   <= 1'b0;
            mode_prev_q  <= DEF_MODE;
            target_q     <= DEF_MODE;
            state_sel_q  <= DEF_MODE;
            stable_cnt_q <= '0;
            rst_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            lock_cnt_q   <= '0;
            req_q        <= 1'b0;
            err_q        <= 1'b0;
            blank_q      <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            ack_sync_q   <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_toggle_i};
            lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], bus.mmcm_locked_i};
            ack_prev_q   <= ack_prev_d;
            mode_prev_q  <= bus.mode_i;
            target_q     <= target_d;
            state_sel_q  <= state_sel_d;
            stable_cnt_q <= stable_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            req_q        <= req_d;
            err_q        <= err_d;
            // Outputs are registered from the next state so they carry no decode glitches.
            blank_q      <= !(state_d inside {IDLE, WAIT_FRAME});
            busy_q       <= state_d != IDLE;
        end
    end
    assign bus.req_toggle_o  = req_q;
    assign bus.state_sel_o   = state_sel_q;
    assign bus.pipe_rst_o    = blank_q;
    assign bus.blank_o       = blank_q;
    assign bus.busy_o        = busy_q;
    assign bus.timeout_err_o = err_q;
endmodule
